// File: rtl/dpram_be_ctl.sv
// True dual-port RAM with byte enables, read-during-write mode, optional
// output register, same-address collision arbitration and post-reset clear.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   busy                 clear sequence running; port requests ignored
//   ena/wea/addra/dia    port A enable, byte write enables, address, data
//   doa/vala             port A read data and 1-cycle valid pulse
//   enb/web/addrb/dib    port B equivalents
//   dob/valb             port B read data and valid pulse
//   coll/coll_addr       collision pulse and last colliding address
module dpram_be_ctl #(
    parameter int DW           = 16,
    parameter int AW           = 10,
    parameter int NB           = DW / 8,
    parameter int RD_MODE      = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          busy,
    input  logic          ena,
    input  logic [NB-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dia,
    output logic [DW-1:0] doa,
    output logic          vala,
    input  logic          enb,
    input  logic [NB-1:0] web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dib,
    output logic [DW-1:0] dob,
    output logic          valb,
    output logic          coll,
    output logic [AW-1:0] coll_addr
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem [DEPTH];

    logic          acc_a, acc_b, wr_a, wr_b, same;
    logic [DW-1:0] old_a, old_b, own_a, own_b, both_ab;
    logic [DW-1:0] rd_a, rd_b;
    logic          mw_a_en, mw_b_en;
    logic [AW-1:0] mw_a_addr;
    logic [DW-1:0] mw_a_dat;

    logic          coll_q, coll_d;
    logic [AW-1:0] coll_addr_q, coll_addr_d;
    logic          p1_val_a_q, p1_val_a_d, p1_val_b_q, p1_val_b_d;
    logic [DW-1:0] p1_dat_a_q, p1_dat_a_d, p1_dat_b_q, p1_dat_b_d;
    logic          p2_val_a_q, p2_val_a_d, p2_val_b_q, p2_val_b_d;
    logic [DW-1:0] p2_dat_a_q, p2_dat_a_d, p2_dat_b_q, p2_dat_b_d;

    // Clear sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = S_READY;
            end
        end
    end

    assign busy = (state_q == S_CLEAR);

    // Access decode, lane merge and arbitration
    always_comb begin
        acc_a = ena && !busy && rst_n;
        acc_b = enb && !busy && rst_n;
        wr_a  = acc_a && (|wea);
        wr_b  = acc_b && (|web);
        same  = (addra == addrb);
        old_a = mem[addra];
        old_b = mem[addrb];
        for (int i = 0; i < NB; i++) begin
            own_a[8*i +: 8]   = wea[i] ? dia[8*i +: 8] : old_a[8*i +: 8];
            own_b[8*i +: 8]   = web[i] ? dib[8*i +: 8] : old_b[8*i +: 8];
            // A wins on lanes both ports write
            both_ab[8*i +: 8] = wea[i] ? dia[8*i +: 8] :
                                web[i] ? dib[8*i +: 8] : old_a[8*i +: 8];
        end
        // The other port's write never shows up in this port's read data
        rd_a = (RD_MODE == 1) ? own_a : old_a;
        rd_b = (RD_MODE == 1) ? own_b : old_b;

        coll_d      = acc_a && acc_b && same && (wr_a || wr_b);
        coll_addr_d = coll_d ? addra : coll_addr_q;

        // Same-address double write folds into a single port-A write
        if (busy) begin
            mw_a_en   = 1'b1;
            mw_a_addr = cnt_q;
            mw_a_dat  = '0;
            mw_b_en   = 1'b0;
        end else begin
            mw_a_en   = wr_a;
            mw_a_addr = addra;
            mw_a_dat  = (acc_b && same) ? both_ab : own_a;
            mw_b_en   = wr_b && !(wr_a && same);
        end
    end

    // Output pipeline
    always_comb begin
        p1_val_a_d = acc_a;
        p1_val_b_d = acc_b;
        p1_dat_a_d = acc_a ? rd_a : p1_dat_a_q;
        p1_dat_b_d = acc_b ? rd_b : p1_dat_b_q;
        p2_val_a_d = p1_val_a_q;
        p2_val_b_d = p1_val_b_q;
        p2_dat_a_d = p1_val_a_q ? p1_dat_a_q : p2_dat_a_q;
        p2_dat_b_d = p1_val_b_q ? p1_dat_b_q : p2_dat_b_q;
    end

    always_ff @(posedge clk) begin
        if (mw_a_en) begin
            mem[mw_a_addr] <= mw_a_dat;
        end
        if (mw_b_en) begin
            mem[addrb] <= own_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
            cnt_q       <= '0;
            coll_q      <= 1'b0;
            coll_addr_q <= '0;
            p1_val_a_q  <= 1'b0;
            p1_val_b_q  <= 1'b0;
            p1_dat_a_q  <= '0;
            p1_dat_b_q  <= '0;
            p2_val_a_q  <= 1'b0;
            p2_val_b_q  <= 1'b0;
            p2_dat_a_q  <= '0;
            p2_dat_b_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coll_q      <= coll_d;
            coll_addr_q <= coll_addr_d;
            p1_val_a_q  <= p1_val_a_d;
            p1_val_b_q  <= p1_val_b_d;
            p1_dat_a_q  <= p1_dat_a_d;
            p1_dat_b_q  <= p1_dat_b_d;
            p2_val_a_q  <= p2_val_a_d;
            p2_val_b_q  <= p2_val_b_d;
            p2_dat_a_q  <= p2_dat_a_d;
            p2_dat_b_q  <= p2_dat_b_d;
        end
    end

    assign doa       = (OUT_REG != 0) ? p2_dat_a_q : p1_dat_a_q;
    assign dob       = (OUT_REG != 0) ? p2_dat_b_q : p1_dat_b_q;
    assign vala      = (OUT_REG != 0) ? p2_val_a_q : p1_val_a_q;
    assign valb      = (OUT_REG != 0) ? p2_val_b_q : p1_val_b_q;
    assign coll      = coll_q;
    assign coll_addr = coll_addr_q;

endmodule

// File: tb/tb_dpram_be_ctl.sv
// Directed bench for dpram_be_ctl: two instances share stimulus,
// u0 = read-first/no out reg, u1 = write-first/out reg, both AW=4.
module tb_dpram_be_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [15:0] dia, dib;

    logic        busy0, vala0, valb0, coll0;
    logic [15:0] doa0, dob0;
    logic [3:0]  ca0;
    logic        busy1, vala1, valb1, coll1;
    logic [15:0] doa1, dob1;
    logic [3:0]  ca1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] s1_doa0, s1_dob0, s2_doa1, s2_dob1;
    logic        s1_va0, s1_vb0, s1_va1, s1_vb1, s1_c0, s1_c1;
    logic        s2_va0, s2_vb0, s2_va1, s2_vb1, s2_c0;
    logic [3:0]  s1_ca0, s2_ca1;

    always #5 clk = ~clk;

    dpram_be_ctl #(.DW(16), .AW(4), .RD_MODE(0), .OUT_REG(0),
                   .CLEAR_ON_RST(1)) u0 (
        .clk(clk), .rst_n(rst_n), .busy(busy0),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .doa(doa0), .vala(vala0),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib),
        .dob(dob0), .valb(valb0),
        .coll(coll0), .coll_addr(ca0)
    );

    dpram_be_ctl #(.DW(16), .AW(4), .RD_MODE(1), .OUT_REG(1),
                   .CLEAR_ON_RST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .busy(busy1),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .doa(doa1), .vala(vala1),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib),
        .dob(dob1), .valb(valb1),
        .coll(coll1), .coll_addr(ca1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access cycle, then idle; captures state one and two cycles later
    task automatic op(input logic ea, input logic [1:0] wa,
                      input logic [3:0] aa, input logic [15:0] da,
                      input logic eb, input logic [1:0] wb,
                      input logic [3:0] ab, input logic [15:0] db);
        ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
        @(negedge clk);
        s1_doa0 = doa0; s1_dob0 = dob0; s1_va0 = vala0; s1_vb0 = valb0;
        s1_va1 = vala1; s1_vb1 = valb1; s1_c0 = coll0; s1_c1 = coll1;
        s1_ca0 = ca0;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        @(negedge clk);
        s2_doa1 = doa1; s2_dob1 = dob1; s2_va1 = vala1; s2_vb1 = valb1;
        s2_va0 = vala0; s2_vb0 = valb0; s2_c0 = coll0; s2_ca1 = ca1;
    endtask

    // Counts cycles with busy high after release, trying to write meanwhile
    task automatic clear_run(output int n, output logic spur);
        ena = 1'b1; wea = 2'b11; addra = 4'd0; dia = 16'hFFFF;
        enb = 1'b1; web = 2'b11; addrb = 4'd0; dib = 16'hFFFF;
        n = 0;
        spur = 1'b0;
        while (busy0 && n < 100) begin
            n++;
            @(negedge clk);
            spur = spur | vala0 | valb0 | vala1 | valb1 | coll0 | coll1;
        end
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    initial begin
        int   n;
        logic spur;
        rst_n = 1'b0;
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        addra = '0; addrb = '0; dia = '0; dib = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy0, 1);
        chk("rst_doa", doa0, 0);
        chk("rst_vala", vala0, 0);
        chk("rst_coll_addr", ca0, 0);
        chk("rst_dob_r", dob1, 0);
        chk("rst_valb_r", valb1, 0);

        rst_n = 1'b1;
        clear_run(n, spur);
        chk("clear_len", n, 16);
        chk("clear_busy_r", busy1, 0);
        chk("clear_no_activity", spur, 0);

        for (int i = 0; i < 16; i++) begin
            op(1, 2'b00, 4'(i), 16'h0, 0, 2'b00, 4'd0, 16'h0);
            chk("clr_rd_doa", s1_doa0, 0);
            chk("clr_rd_vala", s1_va0, 1);
            chk("clr_rd_doa_r", s2_doa1, 0);
            chk("clr_rd_vala_r", s2_va1, 1);
        end

        op(1, 2'b11, 4'd5, 16'hA1B2, 0, 2'b00, 4'd0, 16'h0);
        op(1, 2'b01, 4'd5, 16'h33CC, 0, 2'b00, 4'd0, 16'h0);
        op(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd5, 16'h0);
        chk("be_dob", s1_dob0, 16'hA1CC);
        chk("be_valb", s1_vb0, 1);
        chk("be_valb_pulse", s2_vb0, 0);
        chk("be_valb_r_early", s1_vb1, 0);
        chk("be_valb_r", s2_vb1, 1);
        chk("be_dob_r", s2_dob1, 16'hA1CC);

        op(1, 2'b11, 4'd3, 16'h1111, 0, 2'b00, 4'd0, 16'h0);
        op(1, 2'b11, 4'd3, 16'h2222, 0, 2'b00, 4'd0, 16'h0);
        chk("rdw_read_first", s1_doa0, 16'h1111);
        chk("rdw_write_first", s2_doa1, 16'h2222);
        op(1, 2'b00, 4'd3, 16'h0, 0, 2'b00, 4'd0, 16'h0);
        chk("rdw_after", s1_doa0, 16'h2222);
        chk("rdw_after_r", s2_doa1, 16'h2222);

        op(1, 2'b11, 4'd7, 16'hAAAA, 1, 2'b11, 4'd7, 16'h5555);
        chk("coll_pulse", s1_c0, 1);
        chk("coll_pulse_r", s1_c1, 1);
        chk("coll_addr", s1_ca0, 7);
        chk("coll_pulse_end", s2_c0, 0);
        chk("coll_addr_hold_r", s2_ca1, 7);
        op(1, 2'b00, 4'd7, 16'h0, 0, 2'b00, 4'd0, 16'h0);
        chk("coll_a_wins", s1_doa0, 16'hAAAA);
        chk("coll_a_wins_r", s2_doa1, 16'hAAAA);
        chk("rd_no_coll", s1_c0, 0);
        op(1, 2'b01, 4'd7, 16'hAAAA, 1, 2'b10, 4'd7, 16'h5555);
        chk("coll_lane_pulse", s1_c0, 1);
        chk("coll_lane_dob", s1_dob0, 16'hAAAA);
        chk("coll_lane_dob_r", s2_dob1, 16'h55AA);
        chk("coll_lane_doa_r", s2_doa1, 16'hAAAA);
        op(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd7, 16'h0);
        chk("coll_lane_mix", s1_dob0, 16'h55AA);
        chk("coll_lane_mix_r", s2_dob1, 16'h55AA);

        op(1, 2'b11, 4'd9, 16'h0F0F, 0, 2'b00, 4'd0, 16'h0);
        op(1, 2'b11, 4'd9, 16'h1234, 1, 2'b00, 4'd9, 16'h0);
        chk("xrd_dob", s1_dob0, 16'h0F0F);
        chk("xrd_dob_r", s2_dob1, 16'h0F0F);
        chk("xrd_coll", s1_c0, 1);
        chk("xrd_coll_addr", s1_ca0, 9);
        chk("xrd_doa", s1_doa0, 16'h0F0F);
        chk("xrd_doa_r", s2_doa1, 16'h1234);
        op(0, 2'b00, 4'd0, 16'h0, 1, 2'b00, 4'd9, 16'h0);
        chk("xrd_after", s1_dob0, 16'h1234);
        chk("xrd_after_r", s2_dob1, 16'h1234);

        op(1, 2'b00, 4'd9, 16'h0, 1, 2'b00, 4'd9, 16'h0);
        chk("rr_no_coll", s1_c0, 0);
        chk("rr_no_coll_r", s1_c1, 0);
        chk("rr_doa", s1_doa0, 16'h1234);
        chk("rr_dob_r", s2_dob1, 16'h1234);

        ena = 1'b1; addra = 4'd9; wea = '0;
        @(negedge clk);
        chk("inflight_vala", vala0, 1);
        chk("inflight_doa", doa0, 16'h1234);
        ena = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_vala", vala0, 0);
        chk("mrst_vala_r", vala1, 0);
        chk("mrst_doa", doa0, 0);
        chk("mrst_doa_r", doa1, 0);
        chk("mrst_busy", busy0, 1);
        chk("mrst_coll_addr", ca0, 0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midclr_busy", busy0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_run(n, spur);
        chk("midclr_len", n, 16);
        chk("midclr_no_activity", spur, 0);
        op(1, 2'b00, 4'd9, 16'h0, 1, 2'b00, 4'd5, 16'h0);
        chk("reclr_doa", s1_doa0, 0);
        chk("reclr_vala", s1_va0, 1);
        chk("reclr_dob_r", s2_dob1, 0);
        chk("reclr_valb_r", s2_vb1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_be_ctl.md
Name: dpram_be_ctl

Overview:
- Parametrised single-clock true dual-port RAM with two symmetric read/write ports, A and B.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register with valid flags, same-address collision detection and arbitration, and a post-reset clear sequencer that zeroes the array.
- It is the general-purpose buffer memory for the datapath blocks that need a true dual-port store.

Parameters:
DW, 16, data width in bits; must be a multiple of 8.
AW, 10, address width; depth = 2**AW words.
NB, DW/8, byte-lane count (derived; not overridden).
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
CLEAR_ON_RST, 1, 1 = zero all words after reset release; 0 = skip the clear.

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
busy  output  1  high while the clear sequence runs; port requests are ignored
ena  input  1  port A access enable
wea  input  NB  port A byte write enables; bit i writes dia[8i+7:8i]
addra  input  AW  port A address
dia  input  DW  port A write data
doa  output  DW  port A read data
vala  output  1  doa updated this cycle (1-cycle pulse)
enb, web, addrb, dib, dob, valb: port B equivalents, same widths
coll  output  1  1-cycle pulse: same-address collision detected
coll_addr  output  AW  address of the last collision; held until the next collision

Behaviour:
- Reset (rst_n=0 at posedge):
  - doa, dob, vala, valb, coll and coll_addr go to 0.
  - The pipeline registers clear.
  - The clear counter goes to 0.
  - busy goes to 1 if CLEAR_ON_RST=1, else 0.
  - Array contents are not reset by rst_n itself.
- FSM states: CLEAR and READY.
  - CLEAR: writes 0 to address cnt each cycle, then cnt += 1. After writing address 2**AW-1, go to READY; busy drops on that same edge.
  - CLEAR therefore lasts exactly 2**AW cycles after the first cycle with rst_n=1.
  - CLEAR: ena and enb are ignored (no writes, no valid pulses, no coll).
  - Reset asserted mid-CLEAR restarts the sequence from address 0.
  - READY: normal operation; stays in READY until the next reset.
- Access is a port with en=1 in READY:
  - Each lane i with we[i]=1 writes its byte.
  - The read returns the full word.
  - en=1 with we=0 is a pure read.
- Latency:
  - OUT_REG=0: data appears on do and val pulses on the edge after the request, i.e. in cycle N+1.
  - OUT_REG=1: both appear in cycle N+2.
  - The pipeline is fully pipelined: one access per port per cycle, back-to-back.
- When val=0, the do output holds its last value.
- Same-port read-during-write:
  - RD_MODE=0 returns the pre-write word.
  - RD_MODE=1 returns the merged word: new bytes in written lanes, old bytes elsewhere.
- Cross-port collision: ena=enb=1, addra=addrb, and (|wea or |web).
  - coll pulses in cycle N+1, independent of OUT_REG.
  - coll_addr loads the colliding address.
- Collision arbitration:
  - Both ports write the same lane: port A's byte wins. Lanes written by only one port take that port's byte.
  - A port reading an address the other port writes in the same cycle gets the pre-write word, in both RD_MODE values.
  - Its own-port writes still follow RD_MODE.
- Two reads of the same address are not a collision.
- Address wrap: addresses are AW bits, so there is no out-of-range access.
- Array mapping: one inference-friendly memory array with two ports. Collision and merge logic sits outside the array.

Test Plan:
- CLEAR_ON_RST=1, AW=4:
  - Release rst_n, count cycles → busy high for exactly 16 cycles.
  - During busy, ena=1, wea=2'b11 writing 0xFFFF has no effect.
  - After clear, reads of all 16 addresses return 0x0000 with vala pulsing.
- Byte enables:
  - A writes 0xA1B2 to addr 5 with wea=2'b11, then 0x33CC with wea=2'b01.
  - B then reads addr 5 → dob=0xA1CC.
  - valb pulses 1 cycle later with OUT_REG=0, 2 cycles later with OUT_REG=1.
- Read-during-write, addr 3 holds 0x1111, A writes 0x2222 with ena=1:
  - RD_MODE=0 → doa=0x1111.
  - RD_MODE=1 → doa=0x2222.
  - A later read returns 0x2222 in both modes.
- Collision, addr 7:
  - A writes 0xAAAA and B writes 0x5555 in the same cycle → coll pulses 1 cycle, coll_addr=7.
  - A subsequent read of addr 7 → 0xAAAA.
  - A write with web=2'b10 vs wea=2'b01 → 0x55AA, with coll pulsing.
- Cross read, addr 9 holds 0x0F0F:
  - A writes 0x1234 while B reads addr 9 → dob=0x0F0F and coll=1.
  - Next B read → 0x1234.
- Reset mid-clear: deassert rst_n, wait 5 cycles, reassert for 1 cycle → busy stays high for a full 2**AW cycles after the second release.
- Reset mid-operation with read in flight: vala and doa are 0 after the reset edge.
